// File: rtl/pe_writeback_pkg.sv
// pe_writeback_pkg
//   Shared definitions for the pe_array drain stage. It provides the default
//   lane and word geometry (Q8.8 signed lanes, 8 lanes per word), the width of
//   the latency counter, and the writeback FSM state encoding.
package pe_writeback_pkg;

  localparam int WB_DATA_WIDTH = 16;
  localparam int WB_NUM_PE     = 8;
  localparam int WB_WORD_WIDTH = WB_DATA_WIDTH * WB_NUM_PE;
  localparam int WB_ADDR_WIDTH = 10;

  // PIPE_LAT is limited to 1..15, so PIPE_LAT-1 always fits in 4 bits.
  localparam int WB_LAT_W      = 4;

  typedef enum logic [1:0] {
    WB_IDLE    = 2'd0,
    WB_WAIT    = 2'd1,
    WB_CAPTURE = 2'd2
  } wb_state_t;

endpackage

// File: rtl/pe_writeback_fifo.sv
// wb_fifo
//   Synchronous show-ahead FIFO. The head entry appears on head_o whenever
//   the FIFO is not empty. A push into a full FIFO is refused, even when a pop
//   happens in the same cycle. Only pointers and count are reset; storage is
//   not, and head_o is forced to zero while empty.
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   push_i, push_data_i   write request and data
//   pop_i                 remove the head entry (ignored when empty)
//   head_o                head entry (zero when empty)
//   full_o, empty_o       occupancy flags
//   count_o               number of stored entries
module wb_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push_ok;
  logic             pop_ok;

  assign full_o  = (count == CNT_W'(DEPTH));
  assign empty_o = (count == '0);
  assign count_o = count;

  // Fullness is judged before any same-cycle pop.
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  assign head_o = empty_o ? '0 : mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem[wr_ptr] <= push_data_i;
  end

endmodule

// File: rtl/pe_writeback.sv
// pe_writeback
//   Drain stage behind pe_array. A done_i pulse starts a wait of PIPE_LAT
//   cycles so the array pipeline can settle. The stage then captures wordp_i,
//   applies optional per-lane ReLU, and queues {address, word} in a small
//   FIFO. Queued words go to feature-map memory over a valid/ready port. The
//   write address auto-increments.
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   start_i, base_addr_i  load the address counter with a layer base address
//   relu_en_i           clamp negative lanes to zero (sampled at capture)
//   done_i              last accumulate beat was issued to pe_array
//   wordp_i             partial-sum word from pe_array
//   wr_valid_o, wr_ready_i, wr_addr_o, wr_data_o   memory write port
//   busy_o              FSM not idle
//   stall_o             capture is blocked by a full FIFO
//   err_o               sticky: done_i arrived while not idle
module pe_writeback
  import pe_writeback_pkg::*;
#(
  parameter int DATA_WIDTH = WB_DATA_WIDTH,
  parameter int NUM_PE     = WB_NUM_PE,
  parameter int WORD_WIDTH = NUM_PE * DATA_WIDTH,
  parameter int PIPE_LAT   = 3,
  parameter int FIFO_DEPTH = 2,
  parameter int ADDR_WIDTH = WB_ADDR_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic                  relu_en_i,
  input  logic                  done_i,
  input  logic [WORD_WIDTH-1:0] wordp_i,
  output logic                  wr_valid_o,
  input  logic                  wr_ready_i,
  output logic [ADDR_WIDTH-1:0] wr_addr_o,
  output logic [WORD_WIDTH-1:0] wr_data_o,
  output logic                  busy_o,
  output logic                  stall_o,
  output logic                  err_o
);

  localparam int ENTRY_W = ADDR_WIDTH + WORD_WIDTH;
  localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);

  // Per-lane ReLU. Lanes are signed Q8.8; a negative lane becomes zero and
  // all other lanes pass through unchanged (no saturation, no resizing).
  function automatic logic [WORD_WIDTH-1:0] relu_word(
    input logic [WORD_WIDTH-1:0] w,
    input logic                  en
  );
    logic [WORD_WIDTH-1:0]        r;
    logic signed [DATA_WIDTH-1:0] lane;
    r = w;
    for (int k = 0; k < NUM_PE; k++) begin
      lane = w[k*DATA_WIDTH +: DATA_WIDTH];
      if (en && (lane < 0)) r[k*DATA_WIDTH +: DATA_WIDTH] = '0;
    end
    return r;
  endfunction

  wb_state_t               state;
  logic [WB_LAT_W-1:0]     lat_cnt;
  logic [ADDR_WIDTH-1:0]   addr_cnt;
  logic                    err_q;

  logic                    fifo_full;
  logic                    fifo_empty;
  logic [CNT_W-1:0]        fifo_count;
  logic [ENTRY_W-1:0]      fifo_head;
  logic                    fifo_pop;
  logic                    cap_ok;
  logic [WORD_WIDTH-1:0]   cap_word_p0;

  // ---- capture stage: processed word and push qualifier ----
  assign cap_word_p0 = relu_word(wordp_i, relu_en_i);
  assign cap_ok      = (state == WB_CAPTURE) && (fifo_count < CNT_W'(FIFO_DEPTH));
  assign fifo_pop    = wr_valid_o && wr_ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= WB_IDLE;
      lat_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      // A done_i pulse outside IDLE is dropped but recorded.
      if (done_i && (state != WB_IDLE)) err_q <= 1'b1;
      case (state)
        WB_IDLE: begin
          if (done_i) begin
            state   <= WB_WAIT;
            lat_cnt <= WB_LAT_W'(PIPE_LAT - 1);
          end
        end
        WB_WAIT: begin
          if (lat_cnt == '0) state <= WB_CAPTURE;
          else               lat_cnt <= lat_cnt - WB_LAT_W'(1);
        end
        WB_CAPTURE: begin
          // With a full FIFO, stay here and re-sample wordp_i each cycle.
          if (cap_ok) state <= WB_IDLE;
        end
        default: state <= WB_IDLE;
      endcase
    end
  end

  // A start load wins over the increment. A push in the same cycle has
  // already taken the old counter value into the FIFO entry.
  always_ff @(posedge clk_i) begin
    if (rst_i)        addr_cnt <= '0;
    else if (start_i) addr_cnt <= base_addr_i;
    else if (cap_ok)  addr_cnt <= addr_cnt + ADDR_WIDTH'(1);
  end

  wb_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (cap_ok),
    .push_data_i ({addr_cnt, cap_word_p0}),
    .pop_i       (fifo_pop),
    .head_o      (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  // ---- output stage: head of queue drives the write port ----
  assign wr_valid_o = !fifo_empty;
  assign wr_addr_o  = fifo_head[ENTRY_W-1 -: ADDR_WIDTH];
  assign wr_data_o  = fifo_head[WORD_WIDTH-1:0];
  assign busy_o     = (state != WB_IDLE);
  assign stall_o    = (state == WB_CAPTURE) && fifo_full;
  assign err_o      = err_q;

endmodule
